// File: rtl/fwft_buffer_if.sv
// Ready/valid handshake and data bundle for the first-word-fall-through buffer.
// slave is the buffer's view; master is the view of the logic around it.
interface fwft_buffer_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [WORD_WIDTH-1:0] data_in_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [WORD_WIDTH-1:0] data_out_o;

  modport slave (
    input  in_valid_i, data_in_i, out_ready_i,
    output in_ready_o, out_valid_o, data_out_o
  );

  modport master (
    output in_valid_i, data_in_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_out_o
  );
endinterface

// File: rtl/fwft_buffer.sv
// First-word-fall-through FIFO: inferred dual-port memory, one read-data stage and
// a registered head word, with fill level, threshold flags, flush and high-water mark.
module fwft_buffer #(
  parameter  int WORD_WIDTH   = 8,
  parameter  int DEPTH        = 512,
  parameter  int AFULL_LEVEL  = DEPTH - 4,
  parameter  int AEMPTY_LEVEL = 4,
  localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic                flush_i,
  fwft_buffer_if.slave        bus,
  output logic [ADDR_WIDTH:0] level_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                almost_empty_o,
  output logic                almost_full_o,
  output logic [ADDR_WIDTH:0] max_level_o
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = LW'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = LW'(AEMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_LVL    = LW'(1);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_reg;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  logic [ADDR_WIDTH:0]   level_reg;
  logic [ADDR_WIDTH:0]   level_next;
  logic [ADDR_WIDTH:0]   max_level_reg;
  logic [ADDR_WIDTH:0]   max_level_next;
  logic [ADDR_WIDTH:0]   mem_count;
  logic                  rd_valid_reg;
  logic [WORD_WIDTH-1:0] rd_data_reg;
  logic                  head_valid_reg;
  logic [WORD_WIDTH-1:0] head_data_reg;
  logic                  push;
  logic                  pop;
  logic                  rd_issue;
  logic                  head_load;

  // Ready looks only at the registered level, so a pop while full cannot open a push slot.
  assign bus.in_ready_o  = en_i & ~reset_i & ~flush_i & (level_reg < DEPTH_LVL);
  assign bus.out_valid_o = en_i & ~flush_i & head_valid_reg;
  assign bus.data_out_o  = head_data_reg;

  assign push = bus.in_valid_i & bus.in_ready_o;
  assign pop  = bus.out_valid_o & bus.out_ready_i;

  // Words still in memory; pointers carry one extra bit so full and empty differ.
  assign mem_count = wr_ptr_reg - rd_ptr_reg;

  // Head refills from the read stage; the read stage refills from memory whenever
  // it is empty or is handing its word to the head, which keeps pops bubble-free.
  assign head_load = en_i & ~flush_i & rd_valid_reg & (~head_valid_reg | pop);
  assign rd_issue  = en_i & ~flush_i & (mem_count != '0) & (~rd_valid_reg | head_load);

  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + ONE_LVL;
    end else if (pop && !push) begin
      level_next = level_reg - ONE_LVL;
    end
  end

  assign max_level_next = (level_next > max_level_reg) ? level_next : max_level_reg;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= bus.data_in_i;
    end
    if (rd_issue) begin
      rd_data_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      max_level_reg  <= '0;
      rd_valid_reg   <= 1'b0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else if (flush_i) begin
      // Discard everything in flight; the last head word stays on data_out_o.
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      max_level_reg  <= '0;
      rd_valid_reg   <= 1'b0;
      head_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ONE_LVL;
      end
      if (rd_issue) begin
        rd_ptr_reg <= rd_ptr_reg + ONE_LVL;
      end

      if (rd_issue) begin
        rd_valid_reg <= 1'b1;
      end else if (head_load) begin
        rd_valid_reg <= 1'b0;
      end

      if (head_load) begin
        head_valid_reg <= 1'b1;
        head_data_reg  <= rd_data_reg;
      end else if (pop) begin
        head_valid_reg <= 1'b0;
      end

      level_reg     <= level_next;
      max_level_reg <= max_level_next;
    end
  end

  assign level_o        = level_reg;
  assign max_level_o    = max_level_reg;
  assign empty_o        = (level_reg == '0);
  assign full_o         = (level_reg == DEPTH_LVL);
  assign almost_full_o  = (level_reg >= AFULL_LVL);
  assign almost_empty_o = (level_reg <= AEMPTY_LVL);

endmodule

// File: tb/tb_fwft_buffer.sv
// Directed bench for fwft_buffer: a queue model with per-word age checks every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fwft_buffer;

  localparam int W      = 8;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int AEMPTY = 1;

  logic       clk;
  logic       reset_i;
  logic       en_i;
  logic       flush_i;
  logic [3:0] level;
  logic [3:0] max_level;
  logic       empty;
  logic       full;
  logic       aempty;
  logic       afull;

  fwft_buffer_if #(.WORD_WIDTH(W)) bus ();

  fwft_buffer #(
    .WORD_WIDTH  (W),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL),
    .AEMPTY_LEVEL(AEMPTY)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .flush_i       (flush_i),
    .bus           (bus),
    .level_o       (level),
    .empty_o       (empty),
    .full_o        (full),
    .almost_empty_o(aempty),
    .almost_full_o (afull),
    .max_level_o   (max_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: contents in order, with the number of enabled edges each word has spent inside.
  logic [W-1:0] qd[$];
  int           qa[$];
  int           m_max = 0;

  function automatic bit m_ready();
    return en_i && !reset_i && !flush_i && (qd.size() < DEPTH);
  endfunction

  function automatic bit m_valid();
    return en_i && !flush_i && (qd.size() > 0) && (qa[0] >= 2);
  endfunction

  always @(posedge clk) begin
    bit p;
    bit o;
    p = bus.in_valid_i && m_ready();
    o = m_valid() && bus.out_ready_i;
    if (reset_i || flush_i) begin
      qd.delete();
      qa.delete();
      m_max = 0;
    end else if (en_i) begin
      if (o) begin
        void'(qd.pop_front());
        void'(qa.pop_front());
      end
      for (int i = 0; i < qa.size(); i++) qa[i] = qa[i] + 1;
      if (p) begin
        qd.push_back(bus.data_in_i);
        qa.push_back(0);
      end
      if (qd.size() > m_max) m_max = qd.size();
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_in_ready",  32'(bus.in_ready_o),  32'(m_ready()));
      chk("m_out_valid", 32'(bus.out_valid_o), 32'(m_valid()));
      if (m_valid()) chk("m_data_out", 32'(bus.data_out_o), 32'(qd[0]));
      chk("m_level",     32'(level),     32'(qd.size()));
      chk("m_empty",     32'(empty),     32'(qd.size() == 0));
      chk("m_full",      32'(full),      32'(qd.size() == DEPTH));
      chk("m_afull",     32'(afull),     32'(qd.size() >= AFULL));
      chk("m_aempty",    32'(aempty),    32'(qd.size() <= AEMPTY));
      chk("m_max_level", 32'(max_level), 32'(m_max));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    en_i = 1'b1;
    flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.data_in_i = '0;
    bus.out_ready_i = 1'b0;

    // Reset state
    tick();
    check_en = 1'b1;
    tick();
    chk("rst_in_ready",  32'(bus.in_ready_o),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_data_out",  32'(bus.data_out_o),  32'h00);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_max",       32'(max_level), 32'd0);
    chk("rst_empty",     32'(empty),     32'd1);
    chk("rst_full",      32'(full),      32'd0);
    chk("rst_aempty",    32'(aempty),    32'd1);
    chk("rst_afull",     32'(afull),     32'd0);
    reset_i = 1'b0;
    tick();
    chk("idle_in_ready",  32'(bus.in_ready_o),  32'd1);
    chk("idle_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("idle_empty",     32'(empty),  32'd1);
    chk("idle_aempty",    32'(aempty), 32'd1);
    chk("idle_level",     32'(level),  32'd0);

    // Single word fall-through latency and stall
    bus.in_valid_i = 1'b1;
    bus.data_in_i = 8'hA5;
    tick();
    bus.in_valid_i = 1'b0;
    chk("a5_level_k", 32'(level), 32'd1);
    chk("a5_valid_k", 32'(bus.out_valid_o), 32'd0);
    tick();
    chk("a5_valid_k1", 32'(bus.out_valid_o), 32'd0);
    tick();
    chk("a5_valid_k2", 32'(bus.out_valid_o), 32'd1);
    chk("a5_data_k2",  32'(bus.data_out_o),  32'hA5);
    tick();
    tick();
    chk("a5_stall_valid", 32'(bus.out_valid_o), 32'd1);
    chk("a5_stall_data",  32'(bus.data_out_o),  32'hA5);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk("a5_drained", 32'(level), 32'd0);

    // Fill to full, reject an extra push, then drain with no bubble
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid_i = 1'b1;
      bus.data_in_i = 8'(i);
      tick();
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_afull", 32'(afull), 32'(i + 1 >= 6));
      chk("fill_full",  32'(full),  32'(i + 1 == 8));
    end
    bus.data_in_i = 8'hEE;
    #1;
    chk("full_in_ready", 32'(bus.in_ready_o), 32'd0);
    tick();
    bus.in_valid_i = 1'b0;
    chk("full_level_held", 32'(level), 32'd8);
    chk("full_max", 32'(max_level), 32'd8);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("drain_valid", 32'(bus.out_valid_o), 32'd1);
      chk("drain_data",  32'(bus.data_out_o),  32'(i));
      if (i == 0) chk("drain_ready_before_pop", 32'(bus.in_ready_o), 32'd0);
      tick();
      if (i == 0) chk("drain_ready_after_pop", 32'(bus.in_ready_o), 32'd1);
    end
    bus.out_ready_i = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_max",   32'(max_level), 32'd8);

    // Steady push+pop at level 4 across pointer wrap
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i = 1'b1;
      bus.data_in_i = 8'(8'h10 + i);
      tick();
    end
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    chk("stream_level_start", 32'(level), 32'd4);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid_i = 1'b1;
      bus.out_ready_i = 1'b1;
      bus.data_in_i = 8'(8'h14 + i);
      #1;
      chk("stream_valid", 32'(bus.out_valid_o), 32'd1);
      chk("stream_data",  32'(bus.data_out_o),  32'(8'h10 + i));
      tick();
      chk("stream_level", 32'(level), 32'd4);
    end
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;

    // Flush at level 5 with both handshakes requested
    bus.in_valid_i = 1'b1;
    bus.data_in_i = 8'h28;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    chk("pre_flush_level", 32'(level), 32'd5);
    flush_i = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.data_in_i = 8'h99;
    bus.out_ready_i = 1'b1;
    #1;
    chk("flush_in_ready",  32'(bus.in_ready_o),  32'd0);
    chk("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
    tick();
    flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    chk("post_flush_level", 32'(level), 32'd0);
    chk("post_flush_valid", 32'(bus.out_valid_o), 32'd0);
    chk("post_flush_max",   32'(max_level), 32'd0);
    chk("post_flush_data",  32'(bus.data_out_o), 32'h24);
    bus.in_valid_i = 1'b1;
    bus.data_in_i = 8'h5A;
    tick();
    bus.in_valid_i = 1'b0;
    chk("refill_valid_k", 32'(bus.out_valid_o), 32'd0);
    tick();
    chk("refill_valid_k1", 32'(bus.out_valid_o), 32'd0);
    tick();
    chk("refill_valid_k2", 32'(bus.out_valid_o), 32'd1);
    chk("refill_data",     32'(bus.data_out_o),  32'h5A);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;

    // Enable dropped at level 3 under traffic
    for (int i = 0; i < 3; i++) begin
      bus.in_valid_i = 1'b1;
      bus.data_in_i = 8'(8'h30 + i);
      tick();
    end
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    en_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.data_in_i = 8'h77;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dis_in_ready",  32'(bus.in_ready_o),  32'd0);
      chk("dis_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("dis_level",     32'(level), 32'd3);
    end
    en_i = 1'b1;
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("reen_valid", 32'(bus.out_valid_o), 32'd1);
      chk("reen_data",  32'(bus.data_out_o),  32'(8'h30 + i));
      tick();
    end
    bus.out_ready_i = 1'b0;
    chk("reen_empty", 32'(empty), 32'd1);
    tick();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fwft_buffer.md
# fwft_buffer

Parametrised first-word-fall-through FIFO for the bootloader datapath. It holds its own inferred dual-port memory and a registered output stage, so the head word is presented without a read request. It adds fill level, almost-full/almost-empty thresholds, synchronous flush and a high-water mark. It sits between the USB endpoint logic and the bitstream/config writer, wherever a ready/valid buffer with occupancy visibility is needed.

## Interface
Parameters:
- WORD_WIDTH, 8, data width in bits
- DEPTH, 512, capacity in words; power of two, ≥ 2
- AFULL_LEVEL, DEPTH-4, almost_full_o asserts when level ≥ this value
- AEMPTY_LEVEL, 4, almost_empty_o asserts when level ≤ this value
- ADDR_WIDTH is a derived localparam equal to $clog2(DEPTH); it is not overridable.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge
- reset_i  in  1  reset, synchronous and active-high
- en_i  in  1  block enable; when low, both handshakes are gated and state is held
- flush_i  in  1  synchronous clear of contents
- in_valid_i  in  1  producer has a word
- in_ready_o  out  1  buffer accepts a word
- data_in_i  in  WORD_WIDTH  write data
- out_valid_o  out  1  head word valid on data_out_o
- out_ready_i  in  1  consumer takes the head word
- data_out_o  out  WORD_WIDTH  head word, registered
- level_o  out  ADDR_WIDTH+1  words held, including the output register
- empty_o, full_o  out  1  level == 0 / level == DEPTH
- almost_empty_o, almost_full_o  out  1  threshold flags
- max_level_o  out  ADDR_WIDTH+1  high-water mark of level_o

## Operation
- Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- in_ready_o = en_i & ~reset_i & ~flush_i & (level < DEPTH).
  - It depends only on registered level, with no combinational path from out_ready_i.
  - A pop while full does not permit a same-cycle push.
- out_valid_o = en_i & ~flush_i & head_valid_reg.
- Level update:
  - push only: +1; pop only: −1; both: unchanged.
  - Level never exceeds DEPTH and never goes below 0.
- Storage:
  - Memory write and read pointers wrap modulo DEPTH.
  - The memory has synchronous read.
  - The output register is refilled from memory whenever it is empty, or popped, and memory holds data.
  - Word order is strictly preserved.
- Flags are combinational from the level register only:
  - empty_o, full_o
  - almost_full_o = level ≥ AFULL_LEVEL
  - almost_empty_o = level ≤ AEMPTY_LEVEL
- max_level_o:
  - Updated to level whenever level > max_level.
  - Cleared by reset and flush.
- flush_i has priority over push and pop in the same cycle. Both handshakes are suppressed because the ready/valid outputs are forced low. On the next edge:
  - level = 0, pointers = 0, head invalid
  - max_level = 0
  - data_out_o is held
- en_i low:
  - Pointers, level, memory and head register are frozen.
  - Flags and max_level_o keep reflecting the frozen level.
- Reset overrides everything, including flush.

## Timing
- Reset values:
  - in_ready_o 0 during the reset cycle, then en_i-dependent
  - out_valid_o 0, data_out_o 0
  - level_o 0, max_level_o 0
  - empty_o 1, full_o 0
  - almost_empty_o 1, almost_full_o 0
- First-word latency: a push at edge k into an empty buffer gives out_valid_o = 1 after edge k+2.
- Throughput:
  - Sustained 1 push and 1 pop per cycle.
  - Once out_valid_o is high and memory is non-empty, consecutive pops produce no bubble; the next word is present the cycle after each pop.
- Stall: while out_valid_o & ~out_ready_i, data_out_o is stable.
- Latency of level_o and flags:
  - They update on the edge of the handshake.
  - level_o counts a word from its push edge, even during the 2-cycle fall-through.
- Full boundary: at level == DEPTH, in_ready_o = 0 until the cycle after a pop.
- Empty boundary: at level == 0, out_valid_o = 0; a simultaneous push is not visible at the output until the k+2 rule is met.
- Reset or flush mid-stream: all in-flight words are discarded, including those in the read pipeline.

## Test plan
Bench parameters: DEPTH=8, AFULL_LEVEL=6, AEMPTY_LEVEL=1, WORD_WIDTH=8.
- Reset, then en_i=1, no traffic -> in_ready_o=1, out_valid_o=0, empty_o=1, almost_empty_o=1, level_o=0.
- Push 0xA5 at edge k with out_ready_i=0 -> level_o=1 after edge k; out_valid_o=1 with data_out_o=0xA5 after edge k+2; data held while stalled.
- Push 0x00..0x07 back-to-back with no pops -> level_o=8, full_o=1, almost_full_o=1 (from level 6), in_ready_o=0. Then hold out_ready_i=1 -> 0x00..0x07 out on 8 consecutive cycles with no bubble, and max_level_o=8.
- At level 4, push and pop in the same cycle for 20 cycles with incrementing data -> level_o stays 4; output order matches input; pointers wrap correctly past index 7.
- At level 5, assert flush_i together with in_valid_i and out_ready_i -> no handshake in that cycle; next cycle level_o=0, out_valid_o=0, max_level_o=0; a new push appears 2 cycles later.
- At level 3, drop en_i for 5 cycles under traffic -> in_ready_o=0, out_valid_o=0, level_o stays 3. Re-enable -> the same 3 words drain in order.
